// File: rtl/btn_conditioner.sv
// Button front end for the LED position game: two-flop sync, debounce and
// rise/auto-repeat pulse per button. Optional auto-repeat: BTN_AUTOREPEAT_EN.

module btn_conditioner_chan #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_stable,
  output logic o_pulse
);
  localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_stable;
  logic          r_stable_d;
  logic          w_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync     <= '0;
      r_cnt      <= '0;
      r_stable   <= 1'b0;
      r_stable_d <= 1'b0;
    end else begin
      r_sync     <= {r_sync[0], i_raw};
      r_stable_d <= r_stable;
      // Any sample matching the accepted level restarts the count.
      if (r_sync[1] == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CMAX) begin
        r_stable <= r_sync[1];
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign w_rise   = r_stable & ~r_stable_d;
  assign o_stable = r_stable;

`ifdef BTN_AUTOREPEAT_EN
  localparam int            RW   = $clog2(REPEAT_CYCLES);
  localparam logic [RW-1:0] RMAX = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] r_rcnt;
  logic          w_rep;

  // Gated by r_stable so a debounced release kills the next repeat at once.
  assign w_rep = r_stable & ~w_rise & (r_rcnt == RMAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rcnt <= '0;
    end else if (!r_stable || w_rise || w_rep) begin
      r_rcnt <= '0;
    end else begin
      r_rcnt <= r_rcnt + RW'(1);
    end
  end

  assign o_pulse = w_rise | w_rep;
`else
  logic w_unused_rep_cfg;
  assign w_unused_rep_cfg = (REPEAT_CYCLES < 2);
  assign o_pulse = w_rise;
`endif
endmodule

module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btnU,
  input  logic btnL,
  input  logic btnR,
  output logic dUpp,
  output logic dLef,
  output logic dRig
);
  localparam int NUM_LANES = 3;
  localparam int LN_U = 0;
  localparam int LN_L = 1;
  localparam int LN_R = 2;

  logic [NUM_LANES-1:0] w_raw;
  logic [NUM_LANES-1:0] w_stable;
  logic [NUM_LANES-1:0] w_pulse;
  logic                 w_unused_pulse_u;
  logic                 r_upp;
  logic                 r_lef;
  logic                 r_rig;

  assign w_raw = {btnR, btnL, btnU};

  btn_conditioner_chan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES)
  ) u_chan [NUM_LANES-1:0] (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_raw   (w_raw),
    .o_stable(w_stable),
    .o_pulse (w_pulse)
  );

  // Up is consumed as a level only.
  assign w_unused_pulse_u = w_pulse[LN_U];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_upp <= 1'b0;
      r_lef <= 1'b0;
      r_rig <= 1'b0;
    end else begin
      r_upp <= w_stable[LN_U];
      r_lef <= w_pulse[LN_L] & ~w_pulse[LN_R] & ~w_stable[LN_U];
      r_rig <= w_pulse[LN_R] & ~w_pulse[LN_L] & ~w_stable[LN_U];
    end
  end

  assign dUpp = r_upp;
  assign dLef = r_lef;
  assign dRig = r_rig;
endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Upstream input stage for the LED position game.
- Takes raw asynchronous board buttons (up, left, right) and synchronises and debounces them.
- Produces clean controls for the position block: a debounced level dUpp (game reset/start) and single-cycle pulses dLef and dRig (one shift per press).
- Sits between the board pins and the position block, in the same clk domain.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive clk samples a synchronised input must hold a new value before it is accepted. Must be ≥1. Board build overrides to 1000000.
- REPEAT_CYCLES, 8, auto-repeat pulse interval in clk cycles. Used only with BTN_AUTOREPEAT_EN. Must be ≥2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- btnU  input  1  raw up button, asynchronous, active-high.
- btnL  input  1  raw left button, asynchronous, active-high.
- btnR  input  1  raw right button, asynchronous, active-high.
- dUpp  output  1  debounced up level (game reset while high).
- dLef  output  1  one-cycle left-shift pulse.
- dRig  output  1  one-cycle right-shift pulse.

Behaviour:
- Reset: rst_n low clears, asynchronously, all synchroniser flops, debounced states, counters and output registers. dUpp=0, dLef=0, dRig=0 while rst_n is low and after release. Reset may arrive mid-debounce or mid-pulse; the count is discarded and a button still held at release must debounce again from zero.
- Per-button channel, identical for U, L and R:
  - Synchroniser: two-flop chain, sync = second flop.
  - Debounce counter: width $clog2(DEBOUNCE_CYCLES+1).
  - Counter and state update, each edge:
    - sync == stable → counter <= 0.
    - sync != stable and counter == DEBOUNCE_CYCLES-1 → stable <= sync, counter <= 0.
    - otherwise → counter <= counter+1.
  - Any glitch back to the stable value restarts the count.
  - Rise detect: registered rise = stable & ~stable_d.
- Latency: raw input changes before edge 1 and is held.
  - sync changes at edge 2.
  - stable changes at edge 2+DEBOUNCE_CYCLES.
  - Pulse (for L/R) is high for exactly one cycle after edge 3+DEBOUNCE_CYCLES.
  - dUpp follows stable_U through one output register, so it also changes at edge 3+DEBOUNCE_CYCLES.
  - With the default parameter: pulse after edge 7.
- Output rules (registered, evaluated each edge):
  - dUpp <= stable_U.
  - dLef <= riseL & ~riseR & ~stable_U.
  - dRig <= riseR & ~riseL & ~stable_U.
- Boundary cases:
  - Simultaneous L and R rises in the same cycle: both suppressed, no pulse.
  - L or R rise while up is debounced high: suppressed and not queued.
  - Release of L/R produces no pulse.
  - Holding L/R produces exactly one pulse per press (feature off).
  - Up release deasserts dUpp DEBOUNCE_CYCLES+3 edges after the raw release.
- No combinational path from any input to any output.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined:
  - Each L/R channel adds a repeat counter, width $clog2(REPEAT_CYCLES).
  - The counter clears on the rise pulse and counts while stable stays high.
  - When it reaches REPEAT_CYCLES-1, an extra pulse is issued and the counter clears.
  - Repeat pulses are subject to the same conflict and up-suppression rules as rise pulses.
  - Releasing the button (stable low) or reset clears the counter immediately.
  - Held L with default parameters: pulses at edges 7, 15, 23, …
- Undefined:
  - Exactly one pulse per press, as specified in Behaviour.
  - No repeat logic is synthesised.

Test Plan:
- Reset: rst_n=0 with all buttons high, release rst_n at cycle 10 → all outputs 0 through edge 10+DEBOUNCE_CYCLES+2. dUpp rises after edge 10+7.
- Clean left press: btnL 0→1 held 30 cycles (D=4) → dLef high for exactly one cycle after edge 7. dRig=0, dUpp=0 throughout. No pulse on release.
- Bounce: btnL toggled 1,0,1,0 each cycle, then held high → no pulse during the toggling. Exactly one dLef occurs 7 edges after the final rising transition.
- Simultaneous: btnL and btnR rise in the same cycle and are held → dLef=0 and dRig=0 for the whole hold. Releasing L alone then re-pressing R → one dRig.
- Up priority: btnU held high, then btnR pressed → dUpp=1, dRig never pulses. After btnU releases with btnR still held → no late dRig (feature off).
- BTN_AUTOREPEAT_EN defined, btnR held 40 cycles → dRig pulses after edges 7, 15, 23, 31, 39. Pulses stop within 1 cycle of debounced release. Asserting rst_n=0 mid-hold → pulses stop at once and restart only after a fresh debounce.
